// File: rtl/serial_addsub.sv
// ----------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial adder/subtractor. It is the sequential counterpart of the
// combinational ripple adder: it takes the same operands (A, B, Cin) and
// returns the same result pair (Sum, Cout). One bit is processed per clock,
// LSB first, through a single full-adder cell.
//
// Subtraction is done as A + ~B + ~Cin. The borrow-out is the inverted final
// carry.
//
// An operation started at edge k completes at edge k+WIDTH. On that edge
// Sum/Cout update and done pulses for one cycle. The FSM is already back in
// IDLE during the done cycle, so a start in that cycle is accepted.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only while idle
//   Sub    in   0 = add, 1 = subtract (sampled with start)
//   A      in   operand A, WIDTH bits (sampled with start)
//   B      in   operand B, WIDTH bits (sampled with start)
//   Cin    in   carry-in (add) / borrow-in (subtract), sampled with start
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse when Sum/Cout are updated
//   Sum    out  result, WIDTH bits; holds until the next completion
//   Cout   out  carry-out (add) / borrow-out (subtract)
// ----------------------------------------------------------------------------
module serial_addsub #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             Sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q,     a_d;     // operand A shift register
   logic [WIDTH-1:0] b_q,     b_d;     // operand B (inverted for subtract)
   logic [WIDTH-1:0] res_q,   res_d;   // partial result, filled from MSB side
   logic [CW-1:0]    cnt_q,   cnt_d;   // index of the bit being processed
   logic             c_q,     c_d;     // running carry
   logic             sub_q,   sub_d;   // operation latched at start
   logic [WIDTH-1:0] sum_q,   sum_d;
   logic             cout_q,  cout_d;
   logic             done_q,  done_d;

   // Single full-adder cell on the current LSBs.
   logic fa_s;
   logic fa_c;

   always_comb begin
      fa_s = a_q[0] ^ b_q[0] ^ c_q;
      fa_c = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
   end

   // Next-state and datapath logic.
   always_comb begin
      // NOTE: every signal gets a default before the case statement. This
      // way no path leaves a variable unassigned, and no latch is inferred.
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      sub_d   = sub_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      done_d  = 1'b0;   // done is a pulse; it always drops on the next edge

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               a_d     = A;
               b_d     = Sub ? ~B : B;
               c_d     = Cin ^ Sub;   // ~Cin when subtracting
               cnt_d   = '0;
               res_d   = '0;
               sub_d   = Sub;
            end
         end

         RUN: begin
            c_d   = fa_c;
            res_d = {fa_s, res_q[WIDTH-1:1]};
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = IDLE;
               sum_d   = res_d;            // includes the bit shifted in this edge
               cout_d  = fa_c ^ sub_q;     // borrow = inverted carry
               done_d  = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State registers. The register set is small, so all of it is reset. That
   // way a reset in the middle of an operation leaves nothing stale behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         sub_q   <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments. Every flop samples its _d value
         // from before the edge, whatever order the lines are in.
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         sub_q   <= sub_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign Sum  = sum_q;
   assign Cout = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// ----------------------------------------------------------------------------
// tb_serial_addsub
//
// Directed and random checks for serial_addsub at WIDTH=4 and WIDTH=8.
// Expected {Cout, Sum} values come from an integer arithmetic model. They
// are queued when an operation is launched and popped when done pulses.
// ----------------------------------------------------------------------------
module tb_serial_addsub;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       start4, sub4, cin4, busy4, done4, cout4;
   logic [3:0] a4, b4, sum4;

   logic       start8, sub8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] q4[$];
   logic [15:0] q8[$];

   serial_addsub #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .Sub(sub4), .A(a4), .B(b4),
      .Cin(cin4), .busy(busy4), .done(done4), .Sum(sum4), .Cout(cout4)
   );

   serial_addsub #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .Sub(sub8), .A(a8), .B(b8),
      .Cin(cin8), .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected {Cout, Sum}, computed with plain integer arithmetic.
   function automatic logic [15:0] model(input int w, input bit sub, input int a,
                                         input int b, input int cin);
      int r;
      if (!sub) r = a + b + cin;
      else      r = ((a - b - cin) & ((1 << w) - 1)) | ((a < b + cin) ? (1 << w) : 0);
      return 16'(r);
   endfunction

   // One operation on the 4-bit instance. It checks latency, busy length,
   // that outputs are stable while running, the result, and the done width.
   // With mid_start set, a second start is pulsed during RUN; that start
   // must be ignored.
   task automatic op4(input bit sub, input logic [3:0] a, input logic [3:0] b,
                      input bit cin, input bit mid_start, input string tag);
      int cycles;
      int busy_cnt;
      int extra;
      logic [4:0] held;
      logic [15:0] exp;
      @(negedge clk);
      held   = {cout4, sum4};
      start4 = 1'b1; sub4 = sub; a4 = a; b4 = b; cin4 = cin;
      q4.push_back(model(4, sub, int'(a), int'(b), int'(cin)));
      @(negedge clk);
      start4 = 1'b0;
      // Scramble the operand inputs; they must not affect the result now.
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); sub4 = 1'($urandom);
      cycles = 0; busy_cnt = 0;
      while (!done4 && cycles < 12) begin
         if (busy4) busy_cnt++;
         check({tag, "_hold"}, 16'({cout4, sum4}), 16'(held));
         if (mid_start && cycles == 1) begin
            start4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
         end else begin
            start4 = 1'b0;
         end
         @(negedge clk);
         cycles++;
      end
      start4 = 1'b0;
      check({tag, "_latency"}, 16'(cycles), 16'd4);
      check({tag, "_busy_cycles"}, 16'(busy_cnt), 16'd4);
      check({tag, "_busy_in_done"}, 16'(busy4), 16'd0);
      if (q4.size() == 0) begin
         check({tag, "_queue"}, 16'(q4.size()), 16'd1);
      end else begin
         exp = q4.pop_front();
         check({tag, "_result"}, 16'({cout4, sum4}), exp);
      end
      @(negedge clk);
      check({tag, "_done_width"}, 16'(done4), 16'd0);
      if (mid_start) begin
         extra = 0;
         repeat (8) begin
            if (done4) extra++;
            @(negedge clk);
         end
         check({tag, "_no_second_op"}, 16'(extra), 16'd0);
      end
   endtask

   task automatic op8(input bit sub, input logic [7:0] a, input logic [7:0] b, input bit cin);
      int cycles;
      logic [15:0] exp;
      @(negedge clk);
      start8 = 1'b1; sub8 = sub; a8 = a; b8 = b; cin8 = cin;
      q8.push_back(model(8, sub, int'(a), int'(b), int'(cin)));
      @(negedge clk);
      start8 = 1'b0;
      cycles = 0;
      while (!done8 && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      check("rand8_latency", 16'(cycles), 16'd8);
      exp = (q8.size() != 0) ? q8.pop_front() : 16'hxxxx;
      check("rand8_result", 16'({cout8, sum8}), exp);
   endtask

   initial begin
      int n;
      int last;
      int ndone;
      bit prev;
      logic [15:0] exp;

      rst_n  = 1'b0;
      start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;

      // Reset values
      #2;
      check("reset_busy4", 16'(busy4), 16'd0);
      check("reset_done4", 16'(done4), 16'd0);
      check("reset_out4",  16'({cout4, sum4}), 16'd0);
      check("reset_out8",  16'({busy8, done8, cout8, sum8}), 16'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed operations (4-bit)
      op4(1'b0, 4'b1011, 4'b0100, 1'b0, 1'b0, "add");
      op4(1'b0, 4'b1111, 4'b1101, 1'b1, 1'b0, "add_carry");
      op4(1'b1, 4'b0101, 4'b0011, 1'b0, 1'b0, "sub_pos");
      op4(1'b1, 4'b0011, 4'b0101, 1'b0, 1'b0, "sub_neg");
      op4(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, "sub_borrow_in");
      op4(1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1, "busy_reject");
      op4(1'b1, 4'b0011, 4'b0101, 1'b0, 1'b0, "sub_neg2");

      // Reset in the middle of an operation. The previous result is nonzero
      // here, so clearing it is observable.
      @(negedge clk);
      start4 = 1'b1; sub4 = 1'b0; a4 = 4'b1011; b4 = 4'b0100; cin4 = 1'b0;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rstmid_busy", 16'(busy4), 16'd0);
      check("rstmid_done", 16'(done4), 16'd0);
      check("rstmid_out",  16'({cout4, sum4}), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (10) begin
         @(negedge clk);
         if (done4) ndone++;
      end
      check("rstmid_no_done", 16'(ndone), 16'd0);

      // 8-bit instance with start held high: a result every 9 cycles
      @(negedge clk);
      start8 = 1'b1; sub8 = 1'b0; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
      repeat (4) q8.push_back(model(8, 1'b0, 255, 1, 0));
      n = 0; last = 0; ndone = 0; prev = 1'b0;
      while (ndone < 4 && n < 60) begin
         @(negedge clk);
         n++;
         if (prev) check("held_done_width", 16'(done8), 16'd0);
         prev = done8;
         if (done8) begin
            check("held_gap", 16'(n - last), 16'd9);
            check("held_busy_in_done", 16'(busy8), 16'd0);
            exp = (q8.size() != 0) ? q8.pop_front() : 16'hxxxx;
            check("held_result", 16'({cout8, sum8}), exp);
            last = n;
            ndone++;
            if (ndone == 4) start8 = 1'b0;
         end
      end
      check("held_count", 16'(ndone), 16'd4);
      @(negedge clk);
      check("held_last_width", 16'(done8), 16'd0);
      check("held_idle", 16'(busy8), 16'd0);

      // Random operations
      for (int i = 0; i < 1000; i++)
         op4(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'b0, "rand4");
      for (int i = 0; i < 200; i++)
         op8(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));

      check("queue4_empty", 16'(q4.size()), 16'd0);
      check("queue8_empty", 16'(q8.size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial, multi-cycle adder/subtractor and the sequential counterpart of the team's combinational 4-bit ripple adder. It takes the same operand set (A, B, Cin) and produces the same result pair (Sum, Cout).
- Operands are latched on a start handshake. One bit is processed per clock, LSB first, through a single full-adder cell.
- The result is published with a one-cycle done pulse.
- Used where area matters more than latency. It also serves as a golden-compatible alternative for cross-checking the parallel adder.

Parameters:
- WIDTH, 4, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while idle.
- Sub  input  1  0 = add, 1 = subtract; sampled with start.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- Cin  input  1  carry-in (add) or borrow-in (subtract); sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when Sum/Cout are updated.
- Sum  output  WIDTH  result (sum or difference).
- Cout  output  1  carry-out (add) or borrow-out (subtract).

Behaviour:
- Reset values (async assert, any state):
  - busy=0, done=0, Sum=0, Cout=0.
  - FSM=IDLE; internal shift registers, bit counter and carry cleared.
  - Reset mid-operation aborts it: no done pulse, Sum/Cout return to 0.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on a clock edge with start=1.
  - RUN -> IDLE on the edge that processes bit WIDTH-1.
  - No other transitions.
- Operand capture (IDLE, start=1), all at one edge:
  - shift register a <= A.
  - shift register b <= B when Sub=0, ~B when Sub=1.
  - carry c <= Cin when Sub=0, ~Cin when Sub=1.
  - bit counter <= 0.
  - Sub is latched for the whole operation.
- RUN, each edge:
  - s = a[0] ^ b[0] ^ c; c <= majority(a[0], b[0], c).
  - s shifts into the result register MSB-side; a and b shift right.
  - Counter increments.
- Final edge (counter == WIDTH-1):
  - Sum <= completed result register.
  - Cout <= final carry when latched Sub=0, inverted final carry when Sub=1 (borrow).
  - done <= 1; state <= IDLE.
- Arithmetic:
  - Add: {Cout, Sum} = A + B + Cin, modulo 2^(WIDTH+1).
  - Subtract: Sum = (A - B - Cin) mod 2^WIDTH; Cout = 1 iff A < B + Cin (unsigned).
- Latency: start sampled at edge k -> done high and Sum/Cout valid in the cycle after edge k+WIDTH.
- busy = (state == RUN). It is high from edge k+1 through edge k+WIDTH, and is 0 in the done cycle.
- done is high for exactly one cycle per accepted start. It is deasserted on the next edge regardless of inputs.
- Sum/Cout hold their last value until the next completion. They do not change during RUN.
- start while busy: ignored, with no queuing. A, B, Cin and Sub changes during RUN do not affect the result.
- start asserted in the done cycle: accepted, because the FSM is already IDLE. Back-to-back throughput is one result per WIDTH+1 cycles.
- start held high continuously: a new operation starts every WIDTH+1 cycles.

Test Plan:
- Add, WIDTH=4: A=1011, B=0100, Cin=0, Sub=0, start pulse -> busy high 4 cycles, then done pulse with Sum=1111, Cout=0.
- Add with carry: A=1111, B=1101, Cin=1 -> Sum=1101, Cout=1, done exactly 4 cycles after the start edge.
- Subtract: A=0101, B=0011, Cin=0, Sub=1 -> Sum=0010, Cout=0. Then A=0011, B=0101, Sub=1 -> Sum=1110, Cout=1.
- Busy rejection: start with A=0001, B=0001; mid-RUN pulse start with A=1111, B=1111 -> single done pulse, Sum=0010, Cout=0, no second operation.
- Reset mid-op: start A=1011, B=0100; drop rst_n after 2 cycles -> busy=0, done=0, Sum=0, Cout=0 immediately; no done pulse after release.
- WIDTH=8, start held high: A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1 every 9 cycles; done one cycle wide each time.
- All tests: random self-check of 1000 operations against the behavioural A+B+Cin / A-B-Cin model.
